ram_access_arbiter: RTL and testbench
=====================================

Name: ram_access_arbiter

Overview:
- Shares the single program/data RAM (separate read and write ports, 256 words, 16-bit) between two requesters.
- Requester 1: instruction-fetch (IF) unit, read-only. Requester 2: data unit (DU), read/write.
- Sequences each access through a registered grant/access/response pipeline.
- Checks address range, with an optional write-protect window over the program area.

Parameters:
- ADDR_WIDTH, 8: implemented RAM address bits. Address bits [15:ADDR_WIDTH] must be zero.
- STARVE_LIMIT, 4: consecutive DU grants allowed while IF is waiting, before IF is forced to win.
- PROT_LIMIT, 16'h0060: first writable address when write protect is compiled in.

Ports:
- mclk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  IF read request
- if_addr  in  16  IF read address
- if_gnt  out  1  one-cycle pulse: IF request accepted and latched
- if_rdata  out  16  IF read data, valid while if_rvalid=1
- if_rvalid  out  1  one-cycle pulse: IF response
- if_err  out  1  IF address out of range; qualified by if_rvalid
- du_req  in  1  DU request
- du_we  in  1  DU write (1) / read (0)
- du_addr  in  16  DU address
- du_wdata  in  16  DU write data
- du_gnt  out  1  one-cycle pulse: DU request accepted
- du_rdata  out  16  DU read data; 0 for writes and errors
- du_rvalid  out  1  one-cycle pulse: DU response (read data or write ack)
- du_err  out  1  DU range/protect error; qualified by du_rvalid
- ram_re  out  1  RAM read enable
- ram_raddr  out  16  RAM read address
- ram_rdata  in  16  RAM read data (combinational from RAM)
- ram_we  out  1  RAM write enable; RAM writes on negedge mclk
- ram_waddr  out  16  RAM write address
- ram_wdata  out  16  RAM write data

Behaviour:

Reset and reset values:
- Clock mclk; reset is synchronous and active-high.
- On reset: state=IDLE, starve_cnt=0, latches=0.
- All outputs 0: gnt, rvalid, err, rdata, ram_re, ram_we, ram_*addr, ram_wdata.

States:
- IDLE: samples requests, only in this state.
  - Winner chosen as follows:
    - If only one requester asserts req, it wins.
    - If both assert req, DU wins unless starve_cnt==STARVE_LIMIT, in which case IF wins.
  - On the posedge: latch winner addr/we/wdata, set winner gnt=1 for the next cycle, go to ACC_IF or ACC_DU.
  - With no request, remain in IDLE.
- ACC_IF / ACC_DU: strobes decoded from registered state and latches.
  - Read: ram_re=1, ram_raddr=latched addr.
  - Write: ram_we=1, ram_waddr/ram_wdata=latched values.
  - On the posedge: capture ram_rdata (reads), pulse rvalid next cycle, go to IDLE.
  - Requests are ignored in these states.

Starvation counter:
- starve_cnt increments on each DU grant while if_req=1.
- Clears on any IF grant, or when if_req=0 in IDLE.
- Saturates at STARVE_LIMIT.

Timing:
- Request sampled in cycle t.
- gnt visible in t+1, which is also the RAM strobe cycle.
- rvalid and rdata visible in t+2.
- Next sample is in t+2, so peak throughput is one access per 2 cycles.

Requester rules:
- Hold req and operands stable until gnt is seen.
- Deassert req in the gnt cycle unless presenting a new access.

Range error:
- Condition: any of latched addr[15:ADDR_WIDTH] is nonzero.
- No RAM strobe in the ACC cycle.
- rvalid still pulses with err=1 and rdata=0.

Write ack:
- du_rvalid pulses with du_rdata=0, du_err=0.

Reset in ACC cycle:
- Strobes still assert for that cycle, so the write completes.
- The response is dropped; rvalid stays 0.

Optional Feature:
- Macro: RAM_WRITE_PROTECT_EN.
- Defined: DU write with latched addr < PROT_LIMIT is suppressed (ram_we=0) and answered with du_rvalid=1, du_err=1.
- Undefined: no protect check; all in-range writes reach RAM. PROT_LIMIT is unused.

Test Plan:
- Reset, then IF read 0x0010 (RAM holds 0x1234): if_gnt in t+1, ram_re=1 and ram_raddr=0x0010 in t+1, if_rvalid=1 with if_rdata=0x1234 in t+2, if_err=0.
- DU write 0x0070<=0xBEEF, then DU read 0x0070: ram_we=1 for one cycle, du_rvalid ack with du_rdata=0, then read returns 0xBEEF.
- IF and DU both requesting continuously with STARVE_LIMIT=4: grant order DU,DU,DU,DU,IF,DU... and never more than 4 DU grants between IF grants.
- DU read 0x0100: no ram_re pulse; du_rvalid=1, du_err=1, du_rdata=0.
- With RAM_WRITE_PROTECT_EN: DU write 0x0005<=0xFFFF gives ram_we=0 and du_err=1, and a later read of 0x0005 is unchanged. Without the macro, the same write lands.
- Reset asserted during ACC_DU read: next cycle shows du_rvalid=0 and state IDLE, and a fresh if_req is granted normally.

Source files
------------

// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_access_arbiter
// Description : Shares one 256x16 program/data RAM (separate read and write
//               ports) between the instruction-fetch unit (read-only) and the
//               data unit (read/write). Each access runs through a
//               grant -> RAM access -> response sequence, two cycles per access.
//               Addresses with bits [15:ADDR_WIDTH] set are answered with an
//               error and never reach the RAM.
//               Optional macro RAM_WRITE_PROTECT_EN: DU writes below
//               PROT_LIMIT are blocked and answered with du_err.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_access_arbiter #(
    parameter int          ADDR_WIDTH   = 8,
    parameter int          STARVE_LIMIT = 4,
    parameter logic [15:0] PROT_LIMIT   = 16'h0060
) (
    input  logic        mclk,
    input  logic        reset,
    // instruction-fetch requester
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic [15:0] if_rdata,
    output logic        if_rvalid,
    output logic        if_err,
    // data-unit requester
    input  logic        du_req,
    input  logic        du_we,
    input  logic [15:0] du_addr,
    input  logic [15:0] du_wdata,
    output logic        du_gnt,
    output logic [15:0] du_rdata,
    output logic        du_rvalid,
    output logic        du_err,
    // RAM side
    output logic        ram_re,
    output logic [15:0] ram_raddr,
    input  logic [15:0] ram_rdata,
    output logic        ram_we,
    output logic [15:0] ram_waddr,
    output logic [15:0] ram_wdata
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ACC_IF = 2'd1;
    localparam logic [1:0] c_S_ACC_DU = 2'd2;

    localparam int                 c_CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_starve_cnt;
    logic [15:0]        r_addr;
    logic               r_we;
    logic [15:0]        r_wdata;
    logic               r_err;

    logic               w_pick_if;
    logic               w_pick_du;
    logic [15:0]        w_addr;
    logic               w_range_err;
    logic               w_prot_viol;
    logic               w_acc;

    // IF wins when it is alone or when the DU has used up its starvation budget.
    assign w_pick_if   = if_req & (~du_req | (r_starve_cnt == c_STARVE_MAX));
    assign w_pick_du   = du_req & ~w_pick_if;
    assign w_addr      = w_pick_if ? if_addr : du_addr;
    assign w_range_err = |(w_addr >> ADDR_WIDTH);

`ifdef RAM_WRITE_PROTECT_EN
    // Program area below PROT_LIMIT is read-only for the data unit.
    assign w_prot_viol = w_pick_du & du_we & (du_addr < PROT_LIMIT);
`else
    // Protection compiled out; the term is forced inert but keeps PROT_LIMIT referenced.
    assign w_prot_viol = 1'b0 & (du_addr < PROT_LIMIT);
`endif

    // RAM strobes come straight from the access state and the latched request,
    // so an access cycle always completes even if reset arrives during it.
    assign w_acc     = (r_state == c_S_ACC_IF) || (r_state == c_S_ACC_DU);
    assign ram_re    = w_acc & ~r_we & ~r_err;
    assign ram_raddr = ram_re ? r_addr : 16'h0000;
    assign ram_we    = w_acc & r_we & ~r_err;
    assign ram_waddr = ram_we ? r_addr : 16'h0000;
    assign ram_wdata = ram_we ? r_wdata : 16'h0000;

    // Arbitration FSM, request latches, starvation counter and response registers.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_state      <= c_S_IDLE;
            r_starve_cnt <= '0;
            r_addr       <= 16'h0000;
            r_we         <= 1'b0;
            r_wdata      <= 16'h0000;
            r_err        <= 1'b0;
            if_gnt       <= 1'b0;
            if_rvalid    <= 1'b0;
            if_rdata     <= 16'h0000;
            if_err       <= 1'b0;
            du_gnt       <= 1'b0;
            du_rvalid    <= 1'b0;
            du_rdata     <= 16'h0000;
            du_err       <= 1'b0;
        end else begin
            // pulses and response data default to zero each cycle
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= 16'h0000;
            if_err    <= 1'b0;
            du_gnt    <= 1'b0;
            du_rvalid <= 1'b0;
            du_rdata  <= 16'h0000;
            du_err    <= 1'b0;

            case (r_state)
                c_S_IDLE: begin
                    if (w_pick_if || !if_req) begin
                        r_starve_cnt <= '0;
                    end else if (w_pick_du && (r_starve_cnt != c_STARVE_MAX)) begin
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                    end

                    if (w_pick_if) begin
                        r_addr  <= if_addr;
                        r_we    <= 1'b0;
                        r_wdata <= 16'h0000;
                        r_err   <= w_range_err;
                        if_gnt  <= 1'b1;
                        r_state <= c_S_ACC_IF;
                    end else if (w_pick_du) begin
                        r_addr  <= du_addr;
                        r_we    <= du_we;
                        r_wdata <= du_wdata;
                        r_err   <= w_range_err | w_prot_viol;
                        du_gnt  <= 1'b1;
                        r_state <= c_S_ACC_DU;
                    end
                end

                c_S_ACC_IF: begin
                    if_rvalid <= 1'b1;
                    if_err    <= r_err;
                    if_rdata  <= r_err ? 16'h0000 : ram_rdata;
                    r_state   <= c_S_IDLE;
                end

                c_S_ACC_DU: begin
                    du_rvalid <= 1'b1;
                    du_err    <= r_err;
                    du_rdata  <= (r_err || r_we) ? 16'h0000 : ram_rdata;
                    r_state   <= c_S_IDLE;
                end

                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_access_arbiter
// Description : Directed, table-driven bench for ram_access_arbiter with a
//               behavioural 256x16 RAM (combinational read, negedge write).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_access_arbiter;

`ifdef RAM_WRITE_PROTECT_EN
    localparam bit c_PROT = 1'b1;
`else
    localparam bit c_PROT = 1'b0;
`endif

    logic        mclk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic [15:0] if_rdata;
    logic        if_rvalid;
    logic        if_err;
    logic        du_req;
    logic        du_we;
    logic [15:0] du_addr;
    logic [15:0] du_wdata;
    logic        du_gnt;
    logic [15:0] du_rdata;
    logic        du_rvalid;
    logic        du_err;
    logic        ram_re;
    logic [15:0] ram_raddr;
    logic [15:0] ram_rdata;
    logic        ram_we;
    logic [15:0] ram_waddr;
    logic [15:0] ram_wdata;

    logic [15:0] mem [256];

    int total = 0;
    int bad   = 0;

    ram_access_arbiter u_dut (
        .mclk      (mclk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rdata  (if_rdata),
        .if_rvalid (if_rvalid),
        .if_err    (if_err),
        .du_req    (du_req),
        .du_we     (du_we),
        .du_addr   (du_addr),
        .du_wdata  (du_wdata),
        .du_gnt    (du_gnt),
        .du_rdata  (du_rdata),
        .du_rvalid (du_rvalid),
        .du_err    (du_err),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata)
    );

    always #5 mclk = ~mclk;

    // behavioural RAM
    assign ram_rdata = mem[ram_raddr[7:0]];
    always @(negedge mclk) begin
        if (ram_we) mem[ram_waddr[7:0]] <= ram_wdata;
    end

    typedef struct {
        string       name;
        logic        if_req;
        logic [15:0] if_addr;
        logic        du_req;
        logic        du_we;
        logic [15:0] du_addr;
        logic [15:0] du_wdata;
        logic        e_if_gnt;
        logic        e_du_gnt;
        logic        e_re;
        logic [15:0] e_raddr;
        logic        e_we;
        logic [15:0] e_waddr;
        logic [15:0] e_wdata;
        logic        e_if_rv;
        logic [15:0] e_if_rd;
        logic        e_if_err;
        logic        e_du_rv;
        logic [15:0] e_du_rd;
        logic        e_du_err;
    } vec_t;

    localparam int c_NVEC = 10;
    vec_t vecs [c_NVEC];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req   = 1'b0;
        if_addr  = 16'h0000;
        du_req   = 1'b0;
        du_we    = 1'b0;
        du_addr  = 16'h0000;
        du_wdata = 16'h0000;
    endtask

    string exp_order;
    string got_order;
    byte   ch_got;
    byte   ch_exp;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h05] = 16'h5555;
        mem[8'h10] = 16'h1234;
        mem[8'hFF] = 16'hA5A5;

        //            name            ifr if_addr  dur we du_addr  wdata     ifg dug re raddr    we waddr    wdata     ifv if_rd    ife duv du_rd                      due
        vecs[0] = '{"if_rd_0010",    1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0010, 0, 16'h0000, 16'h0000, 1, 16'h1234, 0, 0, 16'h0000, 0};
        vecs[1] = '{"du_wr_0070",    0, 16'h0000, 1, 1, 16'h0070, 16'hBEEF, 0, 1, 0, 16'h0000, 1, 16'h0070, 16'hBEEF, 0, 16'h0000, 0, 1, 16'h0000, 0};
        vecs[2] = '{"du_rd_0070",    0, 16'h0000, 1, 0, 16'h0070, 16'h0000, 0, 1, 1, 16'h0070, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 16'hBEEF, 0};
        vecs[3] = '{"du_rd_0100",    0, 16'h0000, 1, 0, 16'h0100, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 1};
        vecs[4] = '{"if_rd_8010",    1, 16'h8010, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000, 1, 0, 16'h0000, 0};
        vecs[5] = '{"both_du_wins",  1, 16'h0010, 1, 0, 16'h0070, 16'h0000, 0, 1, 1, 16'h0070, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 16'hBEEF, 0};
        vecs[6] = '{"du_wr_0005",    0, 16'h0000, 1, 1, 16'h0005, 16'hFFFF, 0, 1, 0, 16'h0000, !c_PROT,
                    c_PROT ? 16'h0000 : 16'h0005, c_PROT ? 16'h0000 : 16'hFFFF, 0, 16'h0000, 0, 1, 16'h0000, c_PROT};
        vecs[7] = '{"du_rd_0005",    0, 16'h0000, 1, 0, 16'h0005, 16'h0000, 0, 1, 1, 16'h0005, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1,
                    c_PROT ? 16'h5555 : 16'hFFFF, 0};
        vecs[8] = '{"du_wr_0200",    0, 16'h0000, 1, 1, 16'h0200, 16'h1111, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 1};
        vecs[9] = '{"if_rd_00ff",    1, 16'h00FF, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h00FF, 0, 16'h0000, 16'h0000, 1, 16'hA5A5, 0, 0, 16'h0000, 0};

        // ---------------- reset ----------------
        idle_inputs();
        reset = 1'b1;
        repeat (3) step();
        chk("rst_if_gnt",    {15'b0, if_gnt},    16'h0);
        chk("rst_du_gnt",    {15'b0, du_gnt},    16'h0);
        chk("rst_if_rvalid", {15'b0, if_rvalid}, 16'h0);
        chk("rst_du_rvalid", {15'b0, du_rvalid}, 16'h0);
        chk("rst_if_err",    {15'b0, if_err},    16'h0);
        chk("rst_du_err",    {15'b0, du_err},    16'h0);
        chk("rst_if_rdata",  if_rdata,           16'h0);
        chk("rst_du_rdata",  du_rdata,           16'h0);
        chk("rst_ram_re",    {15'b0, ram_re},    16'h0);
        chk("rst_ram_we",    {15'b0, ram_we},    16'h0);
        chk("rst_ram_raddr", ram_raddr,          16'h0);
        chk("rst_ram_waddr", ram_waddr,          16'h0);
        chk("rst_ram_wdata", ram_wdata,          16'h0);
        reset = 1'b0;
        step();

        // ---------------- table-driven single transactions ----------------
        for (int v = 0; v < c_NVEC; v++) begin
            if_req   = vecs[v].if_req;
            if_addr  = vecs[v].if_addr;
            du_req   = vecs[v].du_req;
            du_we    = vecs[v].du_we;
            du_addr  = vecs[v].du_addr;
            du_wdata = vecs[v].du_wdata;
            step();
            // t+1: grant and RAM strobe cycle
            chk({vecs[v].name, ".if_gnt"}, {15'b0, if_gnt}, {15'b0, vecs[v].e_if_gnt});
            chk({vecs[v].name, ".du_gnt"}, {15'b0, du_gnt}, {15'b0, vecs[v].e_du_gnt});
            chk({vecs[v].name, ".ram_re"}, {15'b0, ram_re}, {15'b0, vecs[v].e_re});
            chk({vecs[v].name, ".ram_we"}, {15'b0, ram_we}, {15'b0, vecs[v].e_we});
            if (vecs[v].e_re) chk({vecs[v].name, ".ram_raddr"}, ram_raddr, vecs[v].e_raddr);
            if (vecs[v].e_we) begin
                chk({vecs[v].name, ".ram_waddr"}, ram_waddr, vecs[v].e_waddr);
                chk({vecs[v].name, ".ram_wdata"}, ram_wdata, vecs[v].e_wdata);
            end
            chk({vecs[v].name, ".early_rvalid"}, {14'b0, if_rvalid, du_rvalid}, 16'h0);
            idle_inputs();
            step();
            // t+2: response cycle
            chk({vecs[v].name, ".if_rvalid"}, {15'b0, if_rvalid}, {15'b0, vecs[v].e_if_rv});
            chk({vecs[v].name, ".du_rvalid"}, {15'b0, du_rvalid}, {15'b0, vecs[v].e_du_rv});
            if (vecs[v].e_if_rv) begin
                chk({vecs[v].name, ".if_rdata"}, if_rdata, vecs[v].e_if_rd);
                chk({vecs[v].name, ".if_err"}, {15'b0, if_err}, {15'b0, vecs[v].e_if_err});
            end
            if (vecs[v].e_du_rv) begin
                chk({vecs[v].name, ".du_rdata"}, du_rdata, vecs[v].e_du_rd);
                chk({vecs[v].name, ".du_err"}, {15'b0, du_err}, {15'b0, vecs[v].e_du_err});
            end
            chk({vecs[v].name, ".late_gnt"}, {14'b0, if_gnt, du_gnt}, 16'h0);
        end

        // ---------------- starvation: both requesting continuously ----------------
        exp_order = "DDDDIDDDDI";
        got_order = "";
        if_req  = 1'b1;
        if_addr = 16'h0010;
        du_req  = 1'b1;
        du_we   = 1'b0;
        du_addr = 16'h0070;
        for (int c = 0; c < 20; c++) begin
            step();
            if (if_gnt && du_gnt) chk("starve_dual_gnt", 16'h1, 16'h0);
            else if (if_gnt) got_order = {got_order, "I"};
            else if (du_gnt) got_order = {got_order, "D"};
        end
        idle_inputs();
        step();
        step();
        chk("starve_grant_count", 16'(got_order.len()), 16'd10);
        for (int g = 0; g < 10; g++) begin
            ch_exp = exp_order[g];
            ch_got = (g < got_order.len()) ? got_order[g] : 8'h3F;
            chk($sformatf("starve_grant_%0d", g), {8'h00, ch_got}, {8'h00, ch_exp});
        end

        // ---------------- reset during ACC_DU read ----------------
        du_req  = 1'b1;
        du_we   = 1'b0;
        du_addr = 16'h0070;
        step();
        chk("rstacc_du_gnt", {15'b0, du_gnt}, 16'h1);
        du_req = 1'b0;
        reset  = 1'b1;
        #1;
        chk("rstacc_strobe_held", {15'b0, ram_re}, 16'h1);
        step();
        chk("rstacc_du_rvalid", {15'b0, du_rvalid}, 16'h0);
        chk("rstacc_du_rdata",  du_rdata,           16'h0);
        chk("rstacc_ram_re",    {15'b0, ram_re},    16'h0);
        reset   = 1'b0;
        if_req  = 1'b1;
        if_addr = 16'h0010;
        step();
        chk("rstacc_if_gnt", {15'b0, if_gnt}, 16'h1);
        chk("rstacc_if_re",  {15'b0, ram_re}, 16'h1);
        idle_inputs();
        step();
        chk("rstacc_if_rvalid", {15'b0, if_rvalid}, 16'h1);
        chk("rstacc_if_rdata",  if_rdata,           16'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
